// File: rtl/twophase_pkg.sv
// Shared definitions for the two-phase clock monitor.
//   CNT_W_DEFAULT : default width of the width/gap counters and measurement outputs
//   St*           : FSM state encoding (IDLE, PHI1 high, PHI1->PHI2 gap, PHI2 high, PHI2->PHI1 gap)
`timescale 1ns / 1ps
package twophase_pkg;

   localparam int unsigned CNT_W_DEFAULT = 16;

   localparam logic [2:0] StIdle  = 3'd0;
   localparam logic [2:0] StP1Hi  = 3'd1;
   localparam logic [2:0] StGap12 = 3'd2;
   localparam logic [2:0] StP2Hi  = 3'd3;
   localparam logic [2:0] StGap21 = 3'd4;

endpackage

// File: rtl/twophase_sync.sv
// Single-bit multi-flop synchronizer for an asynchronous phase input.
// Ports:
//   clk : sampling clock
//   rst : synchronous reset, active-high; clears every stage
//   d   : asynchronous input
//   q   : synchronized output, SYNC_STAGES cycles of latency
`timescale 1ns / 1ps
module twophase_sync
   import twophase_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [SYNC_STAGES-1:0] stages;

   always_ff @(posedge clk) begin
      if (rst) begin
         stages <= '0;
      end else begin
         stages <= {stages[SYNC_STAGES-2:0], d};
      end
   end

   assign q = stages[SYNC_STAGES-1];

endmodule

// File: rtl/twophase_monitor.sv
// Receive-side health monitor for a two-phase non-overlapping clock pair.
// Oversamples PHI1/PHI2, measures high widths and dead gaps, flags faults, reports lock.
// Ports:
//   CLK, RST            : sampling clock, synchronous active-high reset
//   PHI1, PHI2          : asynchronous phase inputs
//   CLR_ERR             : one-cycle pulse clearing the sticky error flags
//   PHI1_WIDTH, PHI2_WIDTH, GAP12, GAP21 : last published period measurement (CLK cycles)
//   MEAS_VALID          : one-cycle pulse when the measurement outputs update
//   OVERLAP_ERR, ORDER_ERR, GAP_ERR : sticky fault flags
//   LOCKED              : LOCK_CYCLES consecutive clean periods since the last error
`timescale 1ns / 1ps
module twophase_monitor
   import twophase_pkg::*;
#(
   parameter int unsigned CNT_W       = CNT_W_DEFAULT,
   parameter int unsigned MIN_GAP     = 1,
   parameter int unsigned LOCK_CYCLES = 4,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             PHI1,
   input  logic             PHI2,
   input  logic             CLR_ERR,
   output logic [CNT_W-1:0] PHI1_WIDTH,
   output logic [CNT_W-1:0] PHI2_WIDTH,
   output logic [CNT_W-1:0] GAP12,
   output logic [CNT_W-1:0] GAP21,
   output logic             MEAS_VALID,
   output logic             OVERLAP_ERR,
   output logic             ORDER_ERR,
   output logic             GAP_ERR,
   output logic             LOCKED
);

   localparam int unsigned LockW = $clog2(LOCK_CYCLES + 1);

   logic s1, s2;

   twophase_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_phi1 (
      .clk (CLK),
      .rst (RST),
      .d   (PHI1),
      .q   (s1)
   );

   twophase_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_phi2 (
      .clk (CLK),
      .rst (RST),
      .d   (PHI2),
      .q   (s2)
   );

   logic [2:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
   logic             armed_q, armed_d;
   // Shadow measurements of the period in progress; published only on completion.
   logic [CNT_W-1:0] w1_q, w1_d, g12_q, g12_d, w2_q, w2_d;
   logic [CNT_W-1:0] gap21_val;
   logic             overlap_evt, order_evt, gap_evt, complete;
   logic [LockW-1:0] lock_cnt_q, lock_cnt_d;

   assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_inc;
      armed_d     = armed_q;
      w1_d        = w1_q;
      g12_d       = g12_q;
      w2_d        = w2_q;
      gap21_val   = '0;
      overlap_evt = 1'b0;
      order_evt   = 1'b0;
      gap_evt     = 1'b0;
      complete    = 1'b0;

      if (s1 && s2) begin
         overlap_evt = 1'b1;
         state_d     = StIdle;
         armed_d     = 1'b0;
         cnt_d       = '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               cnt_d = '0;
               // Arm only after both phases are seen low, so a PHI1 already high is not a rise.
               if (!s1 && !s2) begin
                  armed_d = 1'b1;
               end else if (armed_q && s1) begin
                  state_d = StP1Hi;
                  cnt_d   = CNT_W'(1);
                  armed_d = 1'b0;
               end
            end
            StP1Hi: begin
               if (!s1) begin
                  w1_d  = cnt_q;
                  cnt_d = CNT_W'(1);
                  if (s2) begin
                     g12_d   = '0;
                     state_d = StP2Hi;
                  end else begin
                     state_d = StGap12;
                  end
               end
            end
            StGap12: begin
               if (s2) begin
                  g12_d   = cnt_q;
                  state_d = StP2Hi;
                  cnt_d   = CNT_W'(1);
               end else if (s1) begin
                  order_evt = 1'b1;
                  state_d   = StP1Hi;
                  cnt_d     = CNT_W'(1);
               end
            end
            StP2Hi: begin
               if (!s2) begin
                  w2_d  = cnt_q;
                  cnt_d = CNT_W'(1);
                  if (s1) begin
                     complete = 1'b1;
                     state_d  = StP1Hi;
                  end else begin
                     state_d = StGap21;
                  end
               end
            end
            StGap21: begin
               if (s1) begin
                  complete  = 1'b1;
                  gap21_val = cnt_q;
                  state_d   = StP1Hi;
                  cnt_d     = CNT_W'(1);
               end else if (s2) begin
                  order_evt = 1'b1;
                  state_d   = StP2Hi;
                  cnt_d     = CNT_W'(1);
               end
            end
            default: begin
               state_d = StIdle;
               cnt_d   = '0;
               armed_d = 1'b0;
            end
         endcase
      end

      if (complete) begin
         gap_evt = (g12_q < CNT_W'(MIN_GAP)) || (gap21_val < CNT_W'(MIN_GAP));
      end

      if (overlap_evt || order_evt || gap_evt) begin
         lock_cnt_d = '0;
      end else if (complete && (lock_cnt_q != LockW'(LOCK_CYCLES))) begin
         lock_cnt_d = lock_cnt_q + LockW'(1);
      end else begin
         lock_cnt_d = lock_cnt_q;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         armed_q     <= 1'b0;
         w1_q        <= '0;
         g12_q       <= '0;
         w2_q        <= '0;
         PHI1_WIDTH  <= '0;
         PHI2_WIDTH  <= '0;
         GAP12       <= '0;
         GAP21       <= '0;
         MEAS_VALID  <= 1'b0;
         OVERLAP_ERR <= 1'b0;
         ORDER_ERR   <= 1'b0;
         GAP_ERR     <= 1'b0;
         lock_cnt_q  <= '0;
         LOCKED      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         armed_q     <= armed_d;
         w1_q        <= w1_d;
         g12_q       <= g12_d;
         w2_q        <= w2_d;
         MEAS_VALID  <= complete;
         if (complete) begin
            PHI1_WIDTH <= w1_q;
            GAP12      <= g12_q;
            PHI2_WIDTH <= w2_d;
            GAP21      <= gap21_val;
         end
         // Set wins over a coincident clear.
         OVERLAP_ERR <= (OVERLAP_ERR & ~CLR_ERR) | overlap_evt;
         ORDER_ERR   <= (ORDER_ERR & ~CLR_ERR) | order_evt;
         GAP_ERR     <= (GAP_ERR & ~CLR_ERR) | gap_evt;
         lock_cnt_q  <= lock_cnt_d;
         LOCKED      <= (lock_cnt_d == LockW'(LOCK_CYCLES));
      end
   end

endmodule

// File: tb/tb_twophase_monitor.sv
// Directed self-checking bench for twophase_monitor (CNT_W=16, MIN_GAP=2, LOCK_CYCLES=4,
// SYNC_STAGES=2). Inputs change on the falling edge; outputs are sampled on the falling edge.
`timescale 1ns / 1ps
module tb_twophase_monitor;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        PHI1 = 1'b0;
   logic        PHI2 = 1'b0;
   logic        CLR_ERR = 1'b0;
   logic [15:0] phi1_width, phi2_width, gap12, gap21;
   logic        meas_valid, overlap_err, order_err, gap_err, locked;

   int checks = 0;
   int errors = 0;
   int mv_count = 0;
   int mv_base;
   logic [15:0] last_w1 = '0, last_w2 = '0, last_g12 = '0, last_g21 = '0;
   bit locked_at [16];

   twophase_monitor #(
      .CNT_W       (16),
      .MIN_GAP     (2),
      .LOCK_CYCLES (4),
      .SYNC_STAGES (2)
   ) dut (
      .CLK         (CLK),
      .RST         (RST),
      .PHI1        (PHI1),
      .PHI2        (PHI2),
      .CLR_ERR     (CLR_ERR),
      .PHI1_WIDTH  (phi1_width),
      .PHI2_WIDTH  (phi2_width),
      .GAP12       (gap12),
      .GAP21       (gap21),
      .MEAS_VALID  (meas_valid),
      .OVERLAP_ERR (overlap_err),
      .ORDER_ERR   (order_err),
      .GAP_ERR     (gap_err),
      .LOCKED      (locked)
   );

   always #0.5 CLK = ~CLK;

   // Record every published measurement and the LOCKED value seen with it.
   always @(negedge CLK) begin
      if (meas_valid) begin
         mv_count <= mv_count + 1;
         if (mv_count < 16) locked_at[mv_count] <= locked;
         last_w1  <= phi1_width;
         last_w2  <= phi2_width;
         last_g12 <= gap12;
         last_g21 <= gap21;
      end
   end

   task automatic check_eq(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic drive(input logic p1, input logic p2, input int n);
      PHI1 = p1;
      PHI2 = p2;
      repeat (n) @(negedge CLK);
   endtask

   // Finish the current PHI1 high, run gaps and PHI2, then 4 cycles into the next PHI1 high,
   // which is long enough for the completion pulse to pass the synchronizer.
   task automatic period(input int rest1, input int g12, input int w2, input int g21);
      drive(1'b1, 1'b0, rest1);
      drive(1'b0, 1'b0, g12);
      drive(1'b0, 1'b1, w2);
      drive(1'b0, 1'b0, g21);
      drive(1'b1, 1'b0, 4);
   endtask

   task automatic check_cleared(input string tag);
      check_eq({tag, "_w1"}, int'(phi1_width), 0);
      check_eq({tag, "_g21"}, int'(gap21), 0);
      check_eq({tag, "_mv"}, int'(meas_valid), 0);
      check_eq({tag, "_ovl"}, int'(overlap_err), 0);
      check_eq({tag, "_ord"}, int'(order_err), 0);
      check_eq({tag, "_gap"}, int'(gap_err), 0);
      check_eq({tag, "_lock"}, int'(locked), 0);
   endtask

   initial begin
      repeat (3) @(negedge CLK);
      RST = 1'b0;
      check_cleared("reset");

      // 1: clean 10/3/10/3 periods; first completion at the second PHI1 rise.
      drive(1'b1, 1'b0, 4);
      for (int i = 0; i < 5; i++) period(6, 3, 10, 3);
      check_eq("t1_mv_count", mv_count, 5);
      check_eq("t1_w1", int'(last_w1), 10);
      check_eq("t1_g12", int'(last_g12), 3);
      check_eq("t1_w2", int'(last_w2), 10);
      check_eq("t1_g21", int'(last_g21), 3);
      check_eq("t1_lock_at_3rd", int'(locked_at[2]), 0);
      check_eq("t1_lock_at_4th", int'(locked_at[3]), 1);
      check_eq("t1_locked", int'(locked), 1);
      check_eq("t1_no_err", int'({overlap_err, order_err, gap_err}), 0);

      // 2: PHI2 raised for 2 cycles during PHI1 high.
      mv_base = mv_count;
      drive(1'b1, 1'b1, 2);
      drive(1'b1, 1'b0, 1);
      check_eq("t2_overlap", int'(overlap_err), 1);
      check_eq("t2_unlocked", int'(locked), 0);
      drive(1'b1, 1'b0, 3);
      drive(1'b0, 1'b0, 3);
      drive(1'b0, 1'b1, 10);
      drive(1'b0, 1'b0, 3);
      drive(1'b1, 1'b0, 4);
      check_eq("t2_no_mv", mv_count, mv_base);
      for (int i = 0; i < 4; i++) period(6, 3, 10, 3);
      check_eq("t2_relock_mv", mv_count, mv_base + 4);
      check_eq("t2_relocked", int'(locked), 1);

      // 3: PHI1->PHI2 gap of 1 cycle with MIN_GAP=2.
      period(6, 1, 10, 3);
      check_eq("t3_gap_err", int'(gap_err), 1);
      check_eq("t3_g12", int'(last_g12), 1);
      check_eq("t3_w1", int'(last_w1), 10);
      check_eq("t3_unlocked", int'(locked), 0);

      // 6a: CLR_ERR clears all sticky flags on the next edge.
      CLR_ERR = 1'b1;
      @(negedge CLK);
      CLR_ERR = 1'b0;
      check_eq("t6_clr_ovl", int'(overlap_err), 0);
      check_eq("t6_clr_gap", int'(gap_err), 0);

      // 4: PHI1 pulses twice, then a clean 7/4/8/5 period.
      mv_base = mv_count;
      drive(1'b1, 1'b0, 5);
      drive(1'b0, 1'b0, 3);
      drive(1'b1, 1'b0, 7);
      check_eq("t4_order", int'(order_err), 1);
      drive(1'b0, 1'b0, 4);
      drive(1'b0, 1'b1, 8);
      drive(1'b0, 1'b0, 5);
      drive(1'b1, 1'b0, 4);
      check_eq("t4_mv_count", mv_count, mv_base + 1);
      check_eq("t4_w1", int'(last_w1), 7);
      check_eq("t4_g12", int'(last_g12), 4);
      check_eq("t4_w2", int'(last_w2), 8);
      check_eq("t4_g21", int'(last_g21), 5);

      // 6b: CLR_ERR lands on the same edge as the first overlap sample.
      PHI2 = 1'b1;
      @(negedge CLK);
      @(negedge CLK);
      CLR_ERR = 1'b1;
      PHI2 = 1'b0;
      @(negedge CLK);
      CLR_ERR = 1'b0;
      check_eq("t6_set_wins", int'(overlap_err), 1);
      check_eq("t6_order_cleared", int'(order_err), 0);

      // 6c: reset in the middle of PHI2 high of a measured period.
      drive(1'b1, 1'b0, 3);
      drive(1'b0, 1'b0, 3);
      drive(1'b1, 1'b0, 10);
      drive(1'b0, 1'b0, 3);
      drive(1'b0, 1'b1, 10);
      drive(1'b0, 1'b0, 3);
      drive(1'b1, 1'b0, 4);
      drive(1'b1, 1'b0, 6);
      drive(1'b0, 1'b0, 3);
      drive(1'b0, 1'b1, 5);
      mv_base = mv_count;
      RST = 1'b1;
      drive(1'b0, 1'b1, 2);
      RST = 1'b0;
      check_cleared("t6_rst");
      drive(1'b0, 1'b1, 3);
      drive(1'b0, 1'b0, 3);
      drive(1'b1, 1'b0, 6);
      check_eq("t6_rst_no_mv", mv_count, mv_base);

      // 5: PHI1 held high far beyond the counter range.
      drive(1'b1, 1'b0, 70000);
      drive(1'b0, 1'b0, 3);
      drive(1'b0, 1'b1, 10);
      drive(1'b0, 1'b0, 3);
      drive(1'b1, 1'b0, 4);
      check_eq("t5_mv_count", mv_count, mv_base + 1);
      check_eq("t5_w1_sat", int'(last_w1), 65535);
      check_eq("t5_g12", int'(last_g12), 3);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
